uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
Serial-to-parallel receiver for the team's board UART link. It is the far end of the existing transmitter block.
- Line format: idle high; one low start bit; N data bits, each M clocks long. No stop bit is guaranteed; the line only returns high.
- The block samples each bit at mid-period, assembles an N-bit word, and pulses a valid strobe. A per-bit strobe is also provided for bit-serial consumers.
- It sits between the board RX pin and the RLS coefficient/sample loader.

Parameters:
N, 32, data bits per frame (1..32).
M, 100, clocks per bit period (>=4). H = floor(M/2).

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-low reset.
seriali  input  1  asynchronous serial line, idle high.
data_out  output  N  last complete received word; first received bit lands in data_out[N-1].
valid  output  1  one-cycle pulse when data_out is updated.
bit_data  output  1  value of the bit just sampled.
bit_strobe  output  1  one-cycle pulse per sampled data bit (N per frame).
busy  output  1  high in all states except IDLE.
false_start  output  1  one-cycle pulse when the start bit is not low at its centre.

Behaviour:
- Reset (reset==0, async):
  - state=IDLE, both sync flops=1, counters=0, shift register=0.
  - All outputs 0.
  - Reset mid-frame discards the partial word; no valid is issued.
- Input sync: 2-flop synchronizer; rx = second flop. All decisions use rx only.
- Counters: period counter 32 bits; bit counter ceil(log2(N+1)) bits. Strobe outputs default to 0 every cycle.
- IDLE:
  - period=0, bitcnt=0.
  - If rx==0: go to START.
- START:
  - period increments each cycle.
  - When period==H-1:
    - If rx==0: go to DATA, period=0.
    - Else: pulse false_start, go to IDLE.
- DATA:
  - period increments each cycle.
  - When period==M-1:
    - shreg = {shreg[N-2:0], rx} (MSB-first fill).
    - bit_data=rx, bit_strobe=1, period=0, bitcnt++.
  - When bitcnt reaches N (i.e. on the N-th sample): go to DONE.
- DONE (1 cycle):
  - data_out=shreg, valid=1.
  - Go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rx==1, then go to IDLE.
  - Purpose: a final 0 data bit must not be taken as a new start bit.
  - Must accept a high level as short as 2 clocks. The transmitter can restart after 2 idle-high cycles.
- Exact timing (k0 = clk edge at which seriali is first sampled low):
  - START entered at edge k0+2.
  - Start-bit check at edge k0+2+H.
  - Bit i (0-based) sampled at edge k0+2+H+(i+1)*M.
  - valid registered at edge k0+3+H+N*M.
- data_out holds its value until the next valid. valid and bit_strobe never assert together.
- A glitch shorter than H clocks yields false_start and no bit_strobe.
- Activity on seriali during DATA does not restart the frame.
- Clock mismatch tolerance is under 1/(2N) of a bit; this is not checked.

Decomposition:
- Shared package uart_pkg:
  - State encodings IDLE=0, START=1, DATA=2, DONE=3, WAIT_HIGH=4 (3 bits).
  - Default N/M constants shared with the transmitter.
- One sub-module: uart_sync2, the 2-flop synchronizer with reset value 1. It is reused for other asynchronous inputs.

Test Plan:
- N=8, M=10, word 8'hA5 MSB-first, then idle:
  - valid at edge k0+3+5+80.
  - data_out=8'hA5.
  - 8 bit_strobe pulses with bit_data 1,0,1,0,0,1,0,1.
  - busy falls after WAIT_HIGH.
- N=8, M=10, word 8'h00, line high for only 2 clocks, then word 8'h81:
  - Both words received: first valid with 8'h00, second valid with 8'h81.
  - No false_start.
- 3-clock low glitch on idle line:
  - false_start pulses once.
  - No bit_strobe, no valid; data_out unchanged.
- Reset asserted after 4th bit of a frame, released 2 clocks later, then full frame 8'h3C:
  - No valid for the aborted frame.
  - data_out=8'h3C after the new frame.
- Loopback: existing transmitter (N=32, M=100) drives seriali with 32'hDEADBEEF and then 32'h00000001 back-to-back:
  - Two valid pulses with exactly those values, in order.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

    // Frame geometry shared with the transmitter.
    localparam int UART_N_DEFAULT = 32;
    localparam int UART_M_DEFAULT = 100;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_DONE      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - serial line in, received word and strobes out
interface uart_receiver_if
    import uart_pkg::*;
#(
    parameter int N = UART_N_DEFAULT
);

    logic         seriali;
    logic [N-1:0] data_out;
    logic         valid;
    logic         bit_data;
    logic         bit_strobe;
    logic         busy;
    logic         false_start;

    // Receiver side: samples the line, produces words and strobes.
    modport master (
        input  seriali,
        output data_out, valid, bit_data, bit_strobe, busy, false_start
    );

    // Board side: drives the RX pin and consumes the results.
    modport slave (
        output seriali,
        input  data_out, valid, bit_data, bit_strobe, busy, false_start
    );

endinterface

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer for asynchronous inputs, resets high
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Reset to 1 so an idle-high line never looks like a start bit out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - mid-bit sampling UART receiver, MSB-first word assembly
module uart_receiver
    import uart_pkg::*;
#(
    parameter int N = UART_N_DEFAULT,
    parameter int M = UART_M_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    uart_receiver_if.master rx_if
);

    localparam int H  = M / 2;
    localparam int BW = $clog2(N + 1);

    logic          rx;

    uart_state_e   state_q, state_d;
    logic [31:0]   period_q, period_d;
    logic [BW-1:0] bitcnt_q, bitcnt_d;
    logic [N-1:0]  shreg_q, shreg_d;
    logic [N-1:0]  data_q, data_d;
    logic          valid_q, valid_d;
    logic          bit_data_q, bit_data_d;
    logic          bit_strobe_q, bit_strobe_d;
    logic          false_start_q, false_start_d;

    uart_sync2 u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (rx_if.seriali),
        .q_o   (rx)
    );

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            period_q      <= '0;
            bitcnt_q      <= '0;
            shreg_q       <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            bit_data_q    <= 1'b0;
            bit_strobe_q  <= 1'b0;
            false_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            period_q      <= period_d;
            bitcnt_q      <= bitcnt_d;
            shreg_q       <= shreg_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            bit_data_q    <= bit_data_d;
            bit_strobe_q  <= bit_strobe_d;
            false_start_q <= false_start_d;
        end
    end

    // Frame sequencing: start-bit check at half period, data sampled every M after.
    always_comb begin
        state_d       = state_q;
        period_d      = period_q;
        bitcnt_d      = bitcnt_q;
        shreg_d       = shreg_q;
        data_d        = data_q;
        valid_d       = 1'b0;
        bit_data_d    = bit_data_q;
        bit_strobe_d  = 1'b0;
        false_start_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                period_d = '0;
                bitcnt_d = '0;
                if (!rx) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                period_d = period_q + 32'd1;
                if (period_q == 32'(H - 1)) begin
                    period_d = '0;
                    if (!rx) begin
                        state_d = ST_DATA;
                    end else begin
                        false_start_d = 1'b1;
                        state_d       = ST_IDLE;
                    end
                end
            end

            ST_DATA: begin
                period_d = period_q + 32'd1;
                if (period_q == 32'(M - 1)) begin
                    // Cast keeps the low N bits, so the oldest bit ends in the MSB.
                    shreg_d      = N'({shreg_q, rx});
                    bit_data_d   = rx;
                    bit_strobe_d = 1'b1;
                    period_d     = '0;
                    bitcnt_d     = bitcnt_q + 1'b1;
                    if (bitcnt_q == BW'(N - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                data_d  = shreg_q;
                valid_d = 1'b1;
                state_d = ST_WAIT_HIGH;
            end

            ST_WAIT_HIGH: begin
                // A trailing 0 data bit must not be mistaken for the next start bit.
                if (rx) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rx_if.data_out    = data_q;
    assign rx_if.valid       = valid_q;
    assign rx_if.bit_data    = bit_data_q;
    assign rx_if.bit_strobe  = bit_strobe_q;
    assign rx_if.false_start = false_start_q;
    assign rx_if.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - randomized and directed checks against a frame-level model
module tb_uart_receiver;

    logic clk;
    logic rst_n;
    int   cyc = 0;

    int vectors     = 0;
    int miscompares = 0;

    uart_receiver_if #(.N(8))  if8 ();
    uart_receiver_if #(.N(32)) if32 ();

    uart_receiver #(.N(8), .M(10)) u_rx8 (
        .clk   (clk),
        .reset (rst_n),
        .rx_if (if8)
    );

    uart_receiver #(.N(32), .M(100)) u_rx32 (
        .clk   (clk),
        .reset (rst_n),
        .rx_if (if32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed results, appended only by the monitor.
    logic [31:0] got_w8[$];
    logic [31:0] got_b8[$];
    logic [31:0] got_w32[$];
    logic [31:0] got_b32[$];
    int fs8 = 0, fs32 = 0, overlap = 0, vcyc8 = 0, busy_cyc8 = 0;

    always @(negedge clk) begin
        if (if8.valid) begin
            got_w8.push_back(32'(if8.data_out));
            vcyc8 <= cyc;
        end
        if (if8.bit_strobe)  got_b8.push_back(32'(if8.bit_data));
        if (if8.false_start) fs8 <= fs8 + 1;
        if (if8.busy)        busy_cyc8 <= busy_cyc8 + 1;
        if (if32.valid)      got_w32.push_back(if32.data_out);
        if (if32.bit_strobe) got_b32.push_back(32'(if32.bit_data));
        if (if32.false_start) fs32 <= fs32 + 1;
        if ((if8.valid && if8.bit_strobe) || (if32.valid && if32.bit_strobe))
            overlap <= overlap + 1;
    end

    // Expected results from the frame-level model.
    logic [31:0] exp_w8[$];
    logic [31:0] exp_b8[$];
    logic [31:0] exp_w32[$];
    logic [31:0] exp_b32[$];
    int rd_w[2];
    int rd_b[2];
    int k0[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int which, input logic v);
        if (which == 0) if8.seriali = v;
        else            if32.seriali = v;
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: a frame of word w yields its bits MSB-first, then the word itself.
    task automatic model_push(input int which, input logic [31:0] w, input int nb);
        for (int i = 0; i < nb; i++) begin
            if (which == 0) exp_b8.push_back((w >> (nb - 1 - i)) & 32'd1);
            else            exp_b32.push_back((w >> (nb - 1 - i)) & 32'd1);
        end
        if (which == 0) exp_w8.push_back(w);
        else            exp_w32.push_back(w);
    endtask

    // Drive one frame; caller is positioned just after a falling clock edge.
    task automatic send(input int which, input logic [31:0] w, input int nb,
                        input int m, input int gap);
        drive(which, 1'b0);
        k0[which] = cyc + 1;
        hold(m);
        for (int i = 0; i < nb; i++) begin
            drive(which, w[nb - 1 - i]);
            hold(m);
        end
        drive(which, 1'b1);
        hold(gap);
        model_push(which, w, nb);
    endtask

    task automatic wait_idle(input int which, input string tag);
        int   t;
        logic b;
        t = 0;
        b = (which == 0) ? if8.busy : if32.busy;
        while (b && t < 5000) begin
            @(negedge clk);
            t++;
            b = (which == 0) ? if8.busy : if32.busy;
        end
        check({tag, "_busy_falls"}, 32'(b), 32'd0);
        hold(3);
    endtask

    task automatic compare(input int which, input string tag);
        logic [31:0] gw[$];
        logic [31:0] gb[$];
        logic [31:0] ew[$];
        logic [31:0] eb[$];
        if (which == 0) begin gw = got_w8;  gb = got_b8;  ew = exp_w8;  eb = exp_b8;  end
        else            begin gw = got_w32; gb = got_b32; ew = exp_w32; eb = exp_b32; end
        check({tag, "_nwords"}, 32'(gw.size() - rd_w[which]), 32'(ew.size()));
        for (int i = 0; i < ew.size(); i++)
            if (rd_w[which] + i < gw.size())
                check($sformatf("%s_word%0d", tag, i), gw[rd_w[which] + i], ew[i]);
        check({tag, "_nbits"}, 32'(gb.size() - rd_b[which]), 32'(eb.size()));
        for (int i = 0; i < eb.size(); i++)
            if (rd_b[which] + i < gb.size())
                check($sformatf("%s_bit%0d", tag, i), gb[rd_b[which] + i], eb[i]);
        rd_w[which] = gw.size();
        rd_b[which] = gb.size();
        if (which == 0) begin exp_w8.delete();  exp_b8.delete();  end
        else            begin exp_w32.delete(); exp_b32.delete(); end
    endtask

    initial begin
        int fs_base;
        int busy_base;
        int ngl;
        logic [31:0] w;

        rd_w = '{0, 0};
        rd_b = '{0, 0};
        k0   = '{0, 0};
        rst_n       = 1'b0;
        if8.seriali  = 1'b1;
        if32.seriali = 1'b1;
        hold(3);
        #1;
        check("rst_data_out",    32'(if8.data_out),   32'd0);
        check("rst_valid",       32'(if8.valid),      32'd0);
        check("rst_bit_strobe",  32'(if8.bit_strobe), 32'd0);
        check("rst_bit_data",    32'(if8.bit_data),   32'd0);
        check("rst_busy",        32'(if8.busy),       32'd0);
        check("rst_false_start", 32'(if8.false_start), 32'd0);
        check("rst_busy32",      32'(if32.busy),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hold(5);

        // A5 MSB-first with latency check.
        busy_base = busy_cyc8;
        send(0, 32'hA5, 8, 10, 20);
        wait_idle(0, "a5");
        compare(0, "a5");
        check("a5_valid_edge", 32'(vcyc8), 32'(k0[0] + 3 + 5 + 80));
        check("a5_data_out", 32'(if8.data_out), 32'hA5);
        check("a5_busy_seen", 32'(busy_cyc8 > busy_base + 80), 32'd1);

        // Trailing zero followed by only two idle-high clocks.
        fs_base = fs8;
        send(0, 32'h00, 8, 10, 2);
        send(0, 32'h81, 8, 10, 2);
        wait_idle(0, "b2b");
        compare(0, "b2b");
        check("b2b_no_false_start", 32'(fs8 - fs_base), 32'd0);

        // Short glitch on an idle line.
        fs_base = fs8;
        drive(0, 1'b0);
        hold(3);
        drive(0, 1'b1);
        hold(20);
        compare(0, "glitch");
        check("glitch_false_start", 32'(fs8 - fs_base), 32'd1);
        check("glitch_data_kept", 32'(if8.data_out), 32'h81);

        // Reset after the 4th bit of 3C, then a clean 3C frame.
        drive(0, 1'b0);
        hold(10);
        for (int i = 0; i < 4; i++) begin
            drive(0, (8'h3C >> (7 - i)) & 1'b1);
            hold(10);
        end
        for (int i = 0; i < 4; i++) exp_b8.push_back((32'h3C >> (7 - i)) & 32'd1);
        rst_n = 1'b0;
        drive(0, 1'b1);
        #1;
        check("abort_rst_data_out", 32'(if8.data_out), 32'd0);
        check("abort_rst_busy", 32'(if8.busy), 32'd0);
        hold(2);
        rst_n = 1'b1;
        hold(5);
        compare(0, "abort");
        send(0, 32'h3C, 8, 10, 5);
        wait_idle(0, "after_abort");
        compare(0, "after_abort");
        check("after_abort_data_out", 32'(if8.data_out), 32'h3C);

        // Randomized frames with random short gaps, then random short glitches.
        for (int f = 0; f < 6; f++) begin
            w = 32'($urandom_range(0, 255));
            send(0, w, 8, 10, $urandom_range(2, 12));
        end
        wait_idle(0, "rand");
        compare(0, "rand");
        fs_base = fs8;
        ngl = $urandom_range(1, 3);
        for (int g = 0; g < ngl; g++) begin
            drive(0, 1'b0);
            hold($urandom_range(1, 4));
            drive(0, 1'b1);
            hold(15);
        end
        compare(0, "rand_glitch");
        check("rand_glitch_false_start", 32'(fs8 - fs_base), 32'(ngl));

        // Loopback-style back-to-back 32-bit frames at full bit period.
        send(1, 32'hDEADBEEF, 32, 100, 2);
        send(1, 32'h00000001, 32, 100, 2);
        wait_idle(1, "loop");
        compare(1, "loop");
        check("loop_no_false_start", 32'(fs32), 32'd0);

        check("valid_strobe_overlap", 32'(overlap), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
